spi_modport: RTL and testbench
==============================

Name: spi_modport

Overview:
- SPI slave (target) endpoint that attaches to the slave side of the team's SPI interface bundle.
- Deserialises MOSI into parallel bytes with a one-cycle rx_valid strobe, and serialises a parallel tx_data byte onto MISO.
- SPI mode 0 style, MSB first, 8-bit frames.
- Runs entirely on the serial clock SCL, with no internal system clock.

Parameters:
- DATA_W, 8: frame width in bits; rx_data and tx_data width.

Ports:
- SCL, input, 1: SPI serial clock; all logic on posedge.
- rst_n, input, 1: reset. Synchronous to SCL and active-high: rst_n=1 resets. The name is kept from the codebase.
- CS_n, input, 1: chip select, active-low; high = idle.
- MOSI, input, 1: serial data from master.
- tx_data, input, DATA_W: byte to transmit, captured at the start of each frame.
- MISO, output, 1: serial data to master; registered.
- rx_data, output, DATA_W: last complete received byte; registered.
- rx_valid, output, 1: one-cycle strobe, high for the cycle after a full byte is received.

Behaviour:
- Reset (posedge SCL with rst_n=1):
  - Clears bit_cnt, rx_shift, tx_shift.
  - Sets rx_data=0, rx_valid=0, MISO=0.
  - Overrides everything else, including reset asserted mid-frame.
- State: 3-bit bit_cnt (0..7), rx_shift[DATA_W-1:0], tx_shift[DATA_W-1:0].
- Idle (CS_n=1 at posedge):
  - bit_cnt<=0, rx_valid<=0.
  - MISO, rx_data and the shift registers hold; MISO must not toggle while CS_n is high.
  - A partial frame is discarded: no rx_valid, rx_data unchanged.
- Active (CS_n=0 at posedge), with t = first posedge where CS_n is sampled low:
  - Receive: rx_shift <= {rx_shift[DATA_W-2:0], MOSI}, so the bit sampled at t is the MSB.
  - Transmit when bit_cnt==0: capture tx_data; MISO <= tx_data[DATA_W-1]; tx_shift <= tx_data<<1.
  - Transmit when bit_cnt!=0: MISO <= tx_shift[DATA_W-1]; tx_shift <= tx_shift<<1.
  - So MISO bit i (MSB first) is driven after edge t+i and sampled by the master at edge t+i+1.
  - bit_cnt increments, wrapping 7->0.
  - On the edge where bit_cnt==7 (edge t+7): rx_data <= {rx_shift[DATA_W-2:0], MOSI}, rx_valid <= 1.
  - Net effect: rx_valid is observed high at edge t+8, exactly 8 edges after the CS_n fall.
- rx_valid is a single-cycle pulse: cleared on the next posedge regardless of CS_n.
- Back-to-back frames: if CS_n stays low, the next frame starts at edge t+8 (bit_cnt=0), reloads tx_data, and pulses rx_valid again at t+16. No gap cycle is needed.
- Simultaneous events:
  - CS_n rising on the edge where bit_cnt would be 7: the frame is incomplete (idle wins), so no rx_valid.
  - Reset wins over CS_n.
- tx_data changes mid-frame have no effect until the next frame start.
- No combinational paths from inputs to outputs.

Decomposition:
- Package spi_pkg holds:
  - DATA_W default;
  - CNT_W = $clog2(DATA_W);
  - typedef spi_byte_t = logic [DATA_W-1:0].
- One natural sub-module: spi_shift_reg, a parallel-load/serial-in/serial-out shift register, instantiated twice (rx and tx), or once with both directions.
- The top module holds bit_cnt, the frame control and the output registers.

Test Plan:
- Reset then idle: rst_n=1 for 2 edges, then 0 with CS_n=1 for 5 edges -> MISO=0, rx_data=0x00, rx_valid=0, MISO stable throughout.
- Single frame: CS_n low for 8 edges, MOSI=1,0,1,0,0,1,0,1, tx_data=0xC3 -> rx_valid high exactly at edge 8 for one cycle; rx_data=0xA5; MISO sequence 1,1,0,0,0,0,1,1.
- Back-to-back: CS_n low for 16 edges, MOSI bytes 0x3C then 0xFF, tx_data changed 0x81->0x7E mid-first-frame -> rx_valid at edges 8 and 16; rx_data 0x3C then 0xFF; MISO sends 0x81 then 0x7E.
- Aborted frame: CS_n low for 5 edges then high -> no rx_valid; rx_data keeps its previous value; next full frame after reselect receives correctly from bit 7.
- Reset mid-frame: rst_n=1 at edge 4 of a frame -> outputs 0; after release, with CS_n held low, the next 8 edges form a complete frame with rx_valid at edge 8.
- Idle MISO check: toggle tx_data every edge while CS_n=1 -> MISO never changes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint: default frame width, counter width
// and the per-edge frame phase used to decode the bit counter.
package spi_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = $clog2(DATA_W);

   typedef logic [DATA_W-1:0] spi_byte_t;

   // Role of the current SCL edge within a frame.
   typedef enum logic [1:0] {
      PhIdle,
      PhFirst,
      PhMid,
      PhLast
   } phase_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in shift register (MSB shifts out first), clocked on SCL.
// Synchronous active-high clear; load takes priority over shift.
module spi_shift_reg
#(
   parameter int unsigned WIDTH = spi_pkg::DATA_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;

   always_comb begin
      shift_d = shift_q;
      if (load) begin
         shift_d = load_data;
      end else if (shift_en) begin
         shift_d = {shift_q[WIDTH-2:0], serial_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign data = shift_q;

endmodule

// File: rtl/spi_modport.sv
// SPI mode-0 target endpoint: MSB-first DATA_W-bit frames, runs purely on SCL.
// Reset input rst_n is active-high and synchronous to SCL (name inherited).
module spi_modport
#(
   parameter int unsigned DATA_W = spi_pkg::DATA_W
)
(
   input  logic              SCL,
   input  logic              rst_n,
   input  logic              CS_n,
   input  logic              MOSI,
   input  logic [DATA_W-1:0] tx_data,
   output logic              MISO,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid
);

   import spi_pkg::*;

   localparam int unsigned      BIT_W    = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_CNT = BIT_W'(DATA_W - 1);

   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] tx_shift;
   phase_e            phase;
   logic              active;
   logic              tx_load;
   logic              tx_shift_en;

   always_comb begin
      if (CS_n) begin
         phase = PhIdle;
      end else if (bit_cnt == '0) begin
         phase = PhFirst;
      end else if (bit_cnt == LAST_CNT) begin
         phase = PhLast;
      end else begin
         phase = PhMid;
      end
   end

   assign active      = (phase != PhIdle);
   assign tx_load     = (phase == PhFirst);
   assign tx_shift_en = (phase == PhMid) || (phase == PhLast);

   spi_shift_reg #(
      .WIDTH (DATA_W)
   ) u_rx_shift (
      .clk       (SCL),
      .rst       (rst_n),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (active),
      .serial_in (MOSI),
      .data      (rx_shift)
   );

   // MSB goes straight to MISO on the first edge, so the register keeps the rest pre-shifted.
   spi_shift_reg #(
      .WIDTH (DATA_W)
   ) u_tx_shift (
      .clk       (SCL),
      .rst       (rst_n),
      .load      (tx_load),
      .load_data ({tx_data[DATA_W-2:0], 1'b0}),
      .shift_en  (tx_shift_en),
      .serial_in (1'b0),
      .data      (tx_shift)
   );

   always_ff @(posedge SCL) begin
      if (rst_n) begin
         bit_cnt  <= '0;
         MISO     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         unique case (phase)
            PhIdle: begin
               bit_cnt <= '0;
            end
            PhFirst: begin
               MISO    <= tx_data[DATA_W-1];
               bit_cnt <= bit_cnt + 1'b1;
            end
            PhMid: begin
               MISO    <= tx_shift[DATA_W-1];
               bit_cnt <= bit_cnt + 1'b1;
            end
            PhLast: begin
               MISO     <= tx_shift[DATA_W-1];
               bit_cnt  <= '0;
               rx_data  <= {rx_shift[DATA_W-2:0], MOSI};
               rx_valid <= 1'b1;
            end
            default: begin
               bit_cnt <= '0;
            end
         endcase
      end
   end

   logic unused_shift_bits;
   assign unused_shift_bits = ^{rx_shift[DATA_W-1], tx_shift[DATA_W-2:0]};

endmodule

// File: tb/tb_spi_modport.sv
// Directed self-checking bench for spi_modport: reset, single and back-to-back frames,
// aborted frames, reset mid-frame and MISO stability while deselected.
module tb_spi_modport;

   logic       SCL = 1'b0;
   logic       rst_n;
   logic       CS_n;
   logic       MOSI;
   logic [7:0] tx_data;
   logic       MISO;
   logic [7:0] rx_data;
   logic       rx_valid;

   int checks   = 0;
   int failures = 0;

   always #5 SCL = ~SCL;

   spi_modport #(
      .DATA_W (8)
   ) dut (
      .SCL      (SCL),
      .rst_n    (rst_n),
      .CS_n     (CS_n),
      .MOSI     (MOSI),
      .tx_data  (tx_data),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

   task automatic step();
      @(posedge SCL);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic exp_miso, input logic [7:0] exp_rx,
                             input logic exp_valid);
      check({tag, " miso"}, {7'd0, MISO}, {7'd0, exp_miso});
      check({tag, " rx_data"}, rx_data, exp_rx);
      check({tag, " rx_valid"}, {7'd0, rx_valid}, {7'd0, exp_valid});
   endtask

   // One full frame with CS_n low; tx_mid is applied after the third edge.
   task automatic frame(input string tag, input logic [7:0] mosi_b, input logic [7:0] tx_b,
                        input logic [7:0] tx_mid, input logic [7:0] prev_rx,
                        input logic [7:0] exp_rx);
      for (int i = 0; i < 8; i++) begin
         CS_n = 1'b0;
         MOSI = mosi_b[7-i];
         if (i == 0) tx_data = tx_b;
         else if (i == 3) tx_data = tx_mid;
         step();
         if (i < 7) check_outs($sformatf("%s bit%0d", tag, i), tx_b[7-i], prev_rx, 1'b0);
         else check_outs($sformatf("%s bit%0d", tag, i), tx_b[7-i], exp_rx, 1'b1);
      end
   endtask

   initial begin
      rst_n   = 1'b1;
      CS_n    = 1'b1;
      MOSI    = 1'b0;
      tx_data = 8'hFF;

      // Reset held for two edges, then idle with a non-zero tx_data.
      step();
      step();
      check_outs("reset", 1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         MOSI = ~MOSI;
         step();
         check_outs($sformatf("idle0 e%0d", i), 1'b0, 8'h00, 1'b0);
      end

      frame("single", 8'hA5, 8'hC3, 8'hC3, 8'h00, 8'hA5);
      CS_n = 1'b1;
      step();
      check_outs("pulse_end", 1'b1, 8'hA5, 1'b0);

      // Back-to-back; tx_data changes mid first frame and is picked up by the second.
      frame("b2b0", 8'h3C, 8'h81, 8'h7E, 8'hA5, 8'h3C);
      frame("b2b1", 8'hFF, 8'h7E, 8'h7E, 8'h3C, 8'hFF);

      // Aborted after 5 edges.
      CS_n = 1'b1;
      step();
      check_outs("gap", 1'b0, 8'hFF, 1'b0);
      tx_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         CS_n = 1'b0;
         MOSI = 1'b1;
         step();
         check({"abort5 valid"}, {7'd0, rx_valid}, 8'h00);
      end
      CS_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("abort5 idle%0d", i), 1'b0, 8'hFF, 1'b0);
      end

      // Deselect on the edge that would have completed the frame.
      for (int i = 0; i < 7; i++) begin
         CS_n = 1'b0;
         MOSI = 1'b0;
         step();
         check({"abort7 valid"}, {7'd0, rx_valid}, 8'h00);
      end
      CS_n = 1'b1;
      step();
      check_outs("abort7 edge8", 1'b0, 8'hFF, 1'b0);
      step();
      check_outs("abort7 after", 1'b0, 8'hFF, 1'b0);

      frame("reselect", 8'h5A, 8'h96, 8'h96, 8'hFF, 8'h5A);

      // Reset asserted on the fourth edge of a frame.
      CS_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         CS_n    = 1'b0;
         MOSI    = 1'b1;
         tx_data = 8'hFF;
         step();
         check_outs($sformatf("prerst e%0d", i), 1'b1, 8'h5A, 1'b0);
      end
      rst_n = 1'b1;
      step();
      check_outs("midrst", 1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      frame("post_rst", 8'h69, 8'h3B, 8'h3B, 8'h00, 8'h69);

      // MISO holds its last bit while deselected, whatever tx_data does.
      CS_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
         MOSI    = ~MOSI;
         step();
         check_outs($sformatf("idle_miso e%0d", i), 1'b1, 8'h69, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
